// File: rtl/ram_dump_uart_tx_pkg.sv
// Shared types and constants for the BRAM-to-UART dump path.
// The FSM enum, frame size and baud divider live here.
package ram_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    FRAME
  } state_t;

  localparam int FRAME_BITS = 10;

  function automatic int calc_divider(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/ram_dump_uart_tx_if.sv
// Control and BRAM read-port bundle of the RAM dumper.
// The dumper is the slave; host control plus BRAM form the master.
interface ram_dump_uart_tx_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) ();

  logic                     start;
  logic [ADDRESS_WIDTH-1:0] start_address;
  logic [ADDRESS_WIDTH:0]   length;
  logic                     busy;
  logic                     done;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     read_enable;
  logic [DATA_WIDTH-1:0]    read_data;

  modport master (
    output start,
    output start_address,
    output length,
    input  busy,
    input  done,
    input  read_address,
    input  read_enable,
    output read_data
  );

  modport slave (
    input  start,
    input  start_address,
    input  length,
    output busy,
    output done,
    output read_address,
    output read_enable,
    input  read_data
  );

endinterface

// File: rtl/ram_dump_uart_tx_uart.sv
// 8N1 serializer: bit timer, bit counter, shift register and TX.
// A load pulse starts a frame; frame_done marks the stop-bit end.
module uart_tx_8n1
  import ram_dump_pkg::*;
#(
  parameter int DIVIDER = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done
);

  localparam int TW = $clog2(DIVIDER);

  logic [TW-1:0] timer_q;
  logic [3:0]    bit_q;
  logic [8:0]    shift_q;
  logic          active_q;
  logic          tx_q;
  logic          bit_end;

  assign bit_end = active_q &&
                   (timer_q == TW'(DIVIDER - 1));

  assign frame_done = bit_end &&
                      (bit_q == 4'(FRAME_BITS - 1));

  assign tx = tx_q;

  // The stop bit is pre-shifted in so the last shift yields TX high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (load) begin
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, data};
      active_q <= 1'b1;
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        timer_q <= '0;
        if (frame_done) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_dump_uart_tx.sv
// Walks a BRAM address range and sends each byte out of TX as 8N1.
// start is registered once, so the first read follows one cycle later.
module ram_dump_uart_tx
  import ram_dump_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 12_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int ADDRESS_WIDTH   = 9,
  parameter int DATA_WIDTH      = 8
) (
  input  logic             CLK,
  input  logic             RESETn,
  ram_dump_uart_tx_if.slave bus,
  output logic             TX
);

  localparam int DIVIDER =
    calc_divider(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int AW = ADDRESS_WIDTH;

  if (DIVIDER < 2) begin : g_div_check
    $error("DIVIDER must be at least 2");
  end

  if (DATA_WIDTH != 8) begin : g_dw_check
    $error("DATA_WIDTH must be 8");
  end

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] ra_q, ra_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_q;
  logic          take;
  logic          frame_done;

  assign take = bus.start && (state_q == IDLE) && !start_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      ra_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      ra_q    <= ra_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      start_q <= take;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    ra_d    = ra_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (take) begin
      addr_d  = bus.start_address;
      count_d = bus.length;
    end
    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
            busy_d  = 1'b1;
            ra_d    = addr_q;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD:  state_d = FRAME;
      FRAME: begin
        if (frame_done) begin
          count_d = count_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          if (count_q == (AW+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = FETCH;
            ra_d    = addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.read_enable  = (state_q == FETCH);
  assign bus.read_address = ra_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  uart_tx_8n1 #(
    .DIVIDER(DIVIDER)
  ) u_uart (
    .clk       (CLK),
    .rst_n     (RESETn),
    .load      (state_q == LOAD),
    .data      (bus.read_data),
    .tx        (TX),
    .frame_done(frame_done)
  );

endmodule
